// File: rtl/call_register.sv
// Debounced hall/car buttons latched into sticky per-floor requests, cleared on door-open service.
// Latency: set after the DEBOUNCE_CYCLES-th high sample, clear after one open_door edge; no backpressure.

module call_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturating counter: one press per high episode, never a repeat while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!raw) begin
            cnt <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign press = raw && (cnt == CNT_LAST);
endmodule

module call_register #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw_up,
    input  logic [N-1:0] raw_down,
    input  logic [N-1:0] raw_car,
    input  logic [N-1:0] floor_sensor,
    input  logic         open_door,
    input  logic         direction_up,
    input  logic         direction_down,
    input  logic         fire_alert,
    output logic [N-1:0] button_up,
    output logic [N-1:0] button_down,
    output logic [N-1:0] button_select_floor,
    output logic         any_pending
);
    typedef struct packed {
        logic [N-1:0] up;
        logic [N-1:0] down;
        logic [N-1:0] car;
    } req_t;

    localparam logic [N-1:0] UP_LEGAL   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] DOWN_LEGAL = {{(N-1){1'b1}}, 1'b0};

    req_t         req;
    req_t         req_nxt;
    req_t         press;
    req_t         clr;
    logic         sensor_ok;
    logic [N-1:0] at_floor;
    logic         unused_raw;

    // Top-floor up and ground-floor down have no debouncer at all.
    assign unused_raw = raw_up[N-1] ^ raw_down[0];
    assign press.up[N-1]  = 1'b0;
    assign press.down[0]  = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_floor
        call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_car[i]),
            .press (press.car[i])
        );
        if (i < N - 1) begin : g_up
            call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_up[i]),
                .press (press.up[i])
            );
        end
        if (i > 0) begin : g_down
            call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_down[i]),
                .press (press.down[i])
            );
        end
    end

    // A zero or multi-hot sensor means position is unknown, so nothing is served.
    assign sensor_ok = (floor_sensor != '0) &&
                       ((floor_sensor & (floor_sensor - N'(1))) == '0);

    always_comb begin
        at_floor = '0;
        clr      = '0;
        req_nxt  = '0;
        if (open_door && sensor_ok) begin
            at_floor = floor_sensor;
        end
        clr.car  = at_floor;
        clr.up   = direction_down ? '0 : at_floor;
        clr.down = direction_up   ? '0 : at_floor;
        if (!fire_alert) begin
            req_nxt.up   = (req.up   | press.up)   & ~clr.up   & UP_LEGAL;
            req_nxt.down = (req.down | press.down) & ~clr.down & DOWN_LEGAL;
            req_nxt.car  = (req.car  | press.car)  & ~clr.car;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= '0;
        end else begin
            req <= req_nxt;
        end
    end

    assign button_up           = req.up;
    assign button_down         = req.down;
    assign button_select_floor = req.car;
    assign any_pending         = |req;
endmodule

// File: tb/tb_call_register.sv
// Vector table plus hand sequences for call_register, checked through an expected-value queue.
module tb_call_register;
    localparam int N  = 8;
    localparam int DC = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw_up, raw_down, raw_car, floor_sensor;
    logic         open_door, direction_up, direction_down, fire_alert;
    logic [N-1:0] button_up, button_down, button_select_floor;
    logic         any_pending;

    always #5 clk = ~clk;

    call_register #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .raw_up              (raw_up),
        .raw_down            (raw_down),
        .raw_car             (raw_car),
        .floor_sensor        (floor_sensor),
        .open_door           (open_door),
        .direction_up        (direction_up),
        .direction_down      (direction_down),
        .fire_alert          (fire_alert),
        .button_up           (button_up),
        .button_down         (button_down),
        .button_select_floor (button_select_floor),
        .any_pending         (any_pending)
    );

    typedef struct packed {
        logic [N-1:0] up;
        logic [N-1:0] down;
        logic [N-1:0] car;
        logic         any;
    } exp_t;

    typedef struct {
        logic [N-1:0] ru, rd, rc, fs;
        logic         od, du, dd, fire;
        int           cyc;
        exp_t         e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic [N-1:0] eu, ed, ec);
        exp_t e;
        e.up   = eu;
        e.down = ed;
        e.car  = ec;
        e.any  = |{eu, ed, ec};
        return e;
    endfunction

    task automatic add(input logic [N-1:0] ru, rd, rc, fs,
                       input logic od, du, dd, fire, input int cyc,
                       input logic [N-1:0] eu, ed, ec);
        vec_t v;
        v.ru = ru; v.rd = rd; v.rc = rc; v.fs = fs;
        v.od = od; v.du = du; v.dd = dd; v.fire = fire;
        v.cyc = cyc;
        v.e = mk(eu, ed, ec);
        vecs.push_back(v);
    endtask

    task automatic expect_out(input logic [N-1:0] eu, ed, ec);
        sb.push_back(mk(eu, ed, ec));
    endtask

    task automatic compare(input string tag);
        exp_t e, a;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        a = '{button_up, button_down, button_select_floor, any_pending};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got up=%h down=%h car=%h any=%b, want up=%h down=%h car=%h any=%b",
                     tag, a.up, a.down, a.car, a.any, e.up, e.down, e.car, e.any);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raw_up = '0; raw_down = '0; raw_car = '0; floor_sensor = '0;
        open_door = 1'b0; direction_up = 1'b0; direction_down = 1'b0; fire_alert = 1'b0;

        #12;
        expect_out('0, '0, '0);
        compare("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        //   ru     rd     rc     fs     od  du  dd  fire cyc  eu     ed     ec
        add(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0,   2, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h08, 8'h00, 0, 0, 0, 0,  15, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0,   1, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h08, 8'h00, 0, 0, 0, 0,  16, 8'h00, 8'h00, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0,   3, 8'h00, 8'h00, 8'h08);
        add(8'h04, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0,  16, 8'h04, 8'h04, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h04, 1, 1, 0, 0,   1, 8'h00, 8'h04, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h04, 0, 0, 0, 0,   1, 8'h00, 8'h04, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h04, 1, 0, 0, 0,   1, 8'h00, 8'h00, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0,   1, 8'h00, 8'h00, 8'h08);
        add(8'h02, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0,  16, 8'h02, 8'h00, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0, 0,   2, 8'h02, 8'h00, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0,   2, 8'h02, 8'h00, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0, 0,   1, 8'h00, 8'h00, 8'h08);
        add(8'h00, 8'h00, 8'h00, 8'h08, 1, 0, 0, 0,   1, 8'h00, 8'h00, 8'h00);
        add(8'h80, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 100, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h52, 8'h00, 0, 0, 0, 0,  16, 8'h00, 8'h00, 8'h52);
        add(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1,   1, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h04, 8'h00, 0, 0, 0, 1,  20, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h04, 8'h00, 0, 0, 0, 0,   5, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0,   1, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            raw_up = vecs[i].ru; raw_down = vecs[i].rd; raw_car = vecs[i].rc;
            floor_sensor = vecs[i].fs; open_door = vecs[i].od;
            direction_up = vecs[i].du; direction_down = vecs[i].dd; fire_alert = vecs[i].fire;
            sb.push_back(vecs[i].e);
            repeat (vecs[i].cyc) @(posedge clk);
            @(negedge clk);
            compare($sformatf("vec%0d", i));
        end

        // Car 5 qualifies on the same edge the door opens at floor 5.
        raw_car = 8'h20;
        expect_out('0, '0, '0);
        repeat (DC - 1) @(posedge clk);
        @(negedge clk);
        compare("car5_pre_qualify");
        floor_sensor = 8'h20; open_door = 1'b1;
        expect_out('0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        compare("clear_beats_press");
        floor_sensor = 8'h00; open_door = 1'b0;
        expect_out('0, '0, '0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        compare("car5_held_no_rerequest");
        raw_car = 8'h00;
        @(negedge clk);

        // Requests pending and a counter mid-way when reset drops between edges.
        raw_car = 8'h03;
        expect_out('0, '0, 8'h03);
        repeat (DC) @(posedge clk);
        @(negedge clk);
        compare("rst_setup_pending");
        raw_car = 8'h00;
        @(negedge clk);
        raw_car = 8'h01;
        expect_out('0, '0, 8'h03);
        repeat (10) @(posedge clk);
        @(negedge clk);
        compare("rst_setup_count10");
        #2;
        rst_n = 1'b0;
        expect_out('0, '0, '0);
        #1;
        compare("async_reset_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        expect_out('0, '0, '0);
        repeat (DC - 1) @(posedge clk);
        @(negedge clk);
        compare("rst_count_lost");
        expect_out('0, '0, 8'h01);
        @(posedge clk);
        @(negedge clk);
        compare("post_reset_press");

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
